// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store requesters onto one fixed-latency memory port.
// Optional STARVE_GUARD_EN macro adds a starvation counter that forces a fetch grant.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    localparam int LAT_W = 3;

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
    logic              if_ack_nxt, d_ack_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, d_rdata_nxt;
    logic              mem_en_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              grant_fetch;

`ifdef STARVE_GUARD_EN
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       starved;

    assign starved     = (starve_cnt == 4'(STARVE_MAX));
    assign grant_fetch = if_req && (!d_req || starved);
`else
    assign grant_fetch = if_req && !d_req;
`endif

    assign busy = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        lat_cnt_nxt   = lat_cnt;
        if_ack_nxt    = 1'b0;
        d_ack_nxt     = 1'b0;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;
        mem_en_nxt    = mem_en;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
`ifdef STARVE_GUARD_EN
        starve_cnt_nxt = starve_cnt;
`endif
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_nxt     = grant_fetch ? OWN_FETCH : OWN_DATA;
                    mem_en_nxt    = 1'b1;
                    mem_addr_nxt  = grant_fetch ? if_addr : d_addr;
                    mem_we_nxt    = !grant_fetch && d_we;
                    mem_wdata_nxt = grant_fetch ? '0 : d_wdata;
                    state_nxt     = ISSUE;
`ifdef STARVE_GUARD_EN
                    // Only data grants that left a fetch waiting count toward starvation.
                    if (grant_fetch)
                        starve_cnt_nxt = 4'd0;
                    else if (if_req && !starved)
                        starve_cnt_nxt = starve_cnt + 4'd1;
`endif
                end
            end
            ISSUE: begin
                mem_en_nxt  = 1'b0;
                lat_cnt_nxt = LAT_W'(MEM_LAT - 1);
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    if (owner == OWN_FETCH) begin
                        if_rdata_nxt = mem_rdata;
                        if_ack_nxt   = 1'b1;
                    end else begin
                        d_rdata_nxt = mem_we ? '0 : mem_rdata;
                        d_ack_nxt   = 1'b1;
                    end
                    state_nxt = RESP;
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_FETCH;
            lat_cnt   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef STARVE_GUARD_EN
            starve_cnt <= 4'd0;
`endif
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            lat_cnt   <= lat_cnt_nxt;
            if_ack    <= if_ack_nxt;
            d_ack     <= d_ack_nxt;
            if_rdata  <= if_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
`ifdef STARVE_GUARD_EN
            starve_cnt <= starve_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-3 memory model, transaction-level reference model,
// directed scenarios and randomized requester traffic.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 3;
    localparam int STARVE_MAX = 4;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_ack, d_req, d_we, d_ack;
    logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic              mem_en, mem_we, busy;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: 16 words indexed by address bits [5:2]; read data appears MEM_LAT edges after
    // the sampling edge and is random junk at every other time.
    logic              pl_en = 1'b0;
    logic [3:0]        pl_idx;
    logic [DATA_W-1:0] pl_val;
    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] pipe_data [MEM_LAT];
    logic              pipe_vld [MEM_LAT];
    logic [DATA_W-1:0] junk;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (mem_en && mem_we)
            mem[mem_addr[5:2]] <= mem_wdata;
        pipe_vld[0]  <= rst ? 1'b0 : (mem_en && !mem_we);
        pipe_data[0] <= mem[mem_addr[5:2]];
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_vld[i]  <= rst ? 1'b0 : pipe_vld[i-1];
            pipe_data[i] <= pipe_data[i-1];
        end
        junk <= $urandom;
    end

    assign mem_rdata = (pipe_vld[MEM_LAT-1] === 1'b1) ? pipe_data[MEM_LAT-1] : junk;

    // Reference model: one transaction at a time, tracked by edges elapsed since its grant.
    int                k = -1;
    int                starve = 0;
    bit                m_fetch;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata, m_rd;
    logic [DATA_W-1:0] shadow [16];
    logic              e_busy, e_mem_en, e_if_ack, e_d_ack;
    logic [DATA_W-1:0] e_if_rdata, e_d_rdata;
    bit                model_on = 1'b0;
    bit                chk_regs = 1'b0;

    initial forever begin
        @(posedge clk);
        if (pl_en) shadow[pl_idx] = pl_val;
        if (k == 0) begin
            if (m_we) shadow[m_addr[5:2]] = m_wdata;
            else      m_rd = shadow[m_addr[5:2]];
        end
        chk_regs = 1'b0;
        if (rst) begin
            k = -1; starve = 0;
            e_if_rdata = '0; e_d_rdata = '0;
            m_addr = '0; m_we = 1'b0; m_wdata = '0;
            chk_regs = 1'b1;
        end else if (k < 0) begin
            if (if_req || d_req) begin
                m_fetch = if_req && (!d_req || (GUARD && starve == STARVE_MAX));
                if (m_fetch) starve = 0;
                else if (if_req && starve < STARVE_MAX) starve++;
                m_addr  = m_fetch ? if_addr : d_addr;
                m_we    = !m_fetch && d_we;
                m_wdata = m_fetch ? '0 : d_wdata;
                k = 0;
            end
        end else begin
            k++;
            if (k == MEM_LAT + 2) k = -1;
        end
        e_busy   = (k >= 0);
        e_mem_en = (k == 0);
        e_if_ack = (k == MEM_LAT + 1) && m_fetch;
        e_d_ack  = (k == MEM_LAT + 1) && !m_fetch;
        if (e_if_ack) e_if_rdata = m_rd;
        if (e_d_ack)  e_d_rdata  = m_we ? '0 : m_rd;
        model_on = 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("busy", busy, e_busy);
            check("mem_en", mem_en, e_mem_en);
            check("if_ack", if_ack, e_if_ack);
            check("d_ack", d_ack, e_d_ack);
            check("if_rdata", if_rdata, e_if_rdata);
            if (e_mem_en || chk_regs) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_we", mem_we, m_we);
                check("mem_wdata", mem_wdata, m_wdata);
            end
            if (e_d_ack || chk_regs)
                check("d_rdata", d_rdata, e_d_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input bit fetch, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(fetch ? if_ack : d_ack) && n < 50);
        if (!(fetch ? if_ack : d_ack)) check(fetch ? "if_ack timeout" : "d_ack timeout", 0, 1);
    endtask

    task automatic wait_any(output bit fetch_won);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(if_ack || d_ack) && n < 50);
        if (!(if_ack || d_ack)) check("grant timeout", 0, 1);
        fetch_won = if_ack;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
        d_wdata = $urandom;
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       n;
        bit       fw;
        bit [9:0] seq;

        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; pl_idx = '0; pl_val = '0;
        tick();
        for (int i = 0; i < 16; i++) begin
            pl_en = 1'b1; pl_idx = 4'(i);
            pl_val = (i == 4) ? 32'h0050_0093 : $urandom;
            tick();
        end
        pl_en = 1'b0;
        rst   = 1'b0;

        check("reset busy", busy, 0);
        check("reset mem_en", mem_en, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset if_rdata", if_rdata, 0);

        // Single fetch from 0x10
        if_addr = 32'h10; if_req = 1'b1;
        tick();
        check("fetch mem_en", mem_en, 1);
        check("fetch mem_addr", mem_addr, 32'h10);
        check("fetch mem_we", mem_we, 0);
        wait_ack(1'b1, n);
        check("fetch latency", n, 4);
        check("fetch if_rdata", if_rdata, 32'h0050_0093);
        check("fetch d_ack", d_ack, 0);
        if_req = 1'b0;
        tick();
        check("fetch ack pulse", if_ack, 0);

        // Store then load at 0x100
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        tick();
        check("store mem_we", mem_we, 1);
        check("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        wait_ack(1'b0, n);
        check("store latency", n, 4);
        check("store d_rdata", d_rdata, 0);
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_wdata = '0;
        tick();
        check("load mem_en", mem_en, 1);
        check("load mem_we", mem_we, 0);
        wait_ack(1'b0, n);
        check("load d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();

        // Both requesters held continuously
        do_reset();
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        for (int i = 0; i < 10; i++) begin
            wait_any(fw);
            seq[i] = fw;
        end
        check("grant sequence", seq, GUARD ? 10'b10_0001_0000 : 10'b0);

        // Reset while a load sits in WAIT
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        tick(); tick(); tick();
        rst = 1'b1; d_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rst busy", busy, 0);
        check("rst mem_en", mem_en, 0);
        check("rst d_rdata", d_rdata, 0);
        check("rst mem_addr", mem_addr, 0);
        for (int i = 0; i < 6; i++) begin
            check("rst no d_ack", d_ack, 0);
            tick();
        end

        // d_req withdrawn in ISSUE, fetch pending
        do_reset();
        if_req = 1'b1; if_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h34;
        tick();
        d_req = 1'b0;
        wait_ack(1'b0, n);
        check("withdrawn d_ack latency", n, 4);
        wait_ack(1'b1, n);
        check("fetch after withdraw spacing", n, 6);
        if_req = 1'b0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            if (d_req && d_ack) begin
                if ($urandom_range(0, 1) == 1) d_req = 1'b0; else new_d();
            end else if (!d_req && $urandom_range(0, 3) == 0) begin
                new_d();
            end else if (d_req && busy && $urandom_range(0, 39) == 0) begin
                d_req = 1'b0;
            end
            if (if_req && if_ack) begin
                if ($urandom_range(0, 1) == 1) if_req = 1'b0; else new_if();
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                new_if();
            end else if (if_req && busy && $urandom_range(0, 39) == 0) begin
                if_req = 1'b0;
            end
            tick();
        end
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single synchronous memory port between the instruction-fetch requester and the load/store requester. It arbitrates between the two, sequences each access through a fixed-latency memory, and returns read data with a one-cycle acknowledge pulse. It sits between the PC/fetch path and the data-memory path of the RV32I core, in front of the unified memory. One access is in flight at a time.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles (legal 1..8), counted from the edge that samples mem_en to the edge where mem_rdata is valid
- STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced (legal 1..15)

Ports:
- clk  in  1  rising-edge clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_ack  out  1  one-cycle pulse; fetch access complete
- if_rdata  out  DATA_W  fetched word; valid while if_ack is high, held until the next fetch ack
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse; data access complete
- d_rdata  out  DATA_W  load data; valid while d_ack is high; 0 after a store
- mem_en  out  1  memory access strobe, high for exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP. The owner register (FETCH or DATA) is latched on leaving IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: choose the owner, register mem_addr, mem_we and mem_wdata from the owner, set mem_en=1, go to ISSUE.
- Arbitration order:
  - Data wins over fetch.
  - If the starvation count equals STARVE_MAX and if_req=1, fetch wins.
- Starvation count:
  - Increments on each DATA grant made while if_req=1.
  - Clears on any FETCH grant.
  - Saturates at STARVE_MAX.
- ISSUE: mem_en←0, lat_cnt←MEM_LAT−1, go to WAIT.
- WAIT:
  - If lat_cnt=0: capture mem_rdata into the owner's rdata register (0 for a store), pulse the owner's ack, go to RESP.
  - Otherwise decrement lat_cnt.
- RESP: ack←0, go to IDLE. Requests are not sampled in RESP, so the requester has one cycle to drop or change req.
- mem_we and mem_wdata are 0 when the access is a fetch.
- A store is issued as a single-cycle mem_en with mem_we=1 and follows the same timing as a load.
- If req is withdrawn before ack, the access still completes and ack still pulses; the requester ignores it.
- Back-to-back requests are supported: a held or new request is arbitrated in the IDLE cycle after RESP.

## Timing

- Arbitration runs at edge E0 (state IDLE, req high).
- mem_en is high in the cycle after E0; the memory samples it at E1.
- mem_rdata is captured at edge E(MEM_LAT+1); ack is high during the following cycle.
- Request-to-ack latency is MEM_LAT+1 edges. Throughput is one access per MEM_LAT+3 cycles.
- Reset values, applied on any edge with rst=1 and in any state:
  - State, counters and owner: state=IDLE, lat_cnt=0, starvation count=0, owner=FETCH.
  - Outputs: if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- Reset mid-access: in-flight read data is discarded and no ack is produced. A store already sampled by the memory is not undone.
- Simultaneous if_req and d_req in IDLE resolve per the arbitration order. The loser keeps its req and is served next.

## Configuration

- STARVE_GUARD_EN defined: the starvation counter and forced fetch grant are included as described under Operation.
- STARVE_GUARD_EN undefined: the counter logic is removed and data has strict priority over fetch. STARVE_MAX is ignored.

## Test plan

- Single fetch, MEM_LAT=1, if_addr=0x0000_0010, memory returns 0x0050_0093: mem_en is one cycle with mem_addr=0x10 and mem_we=0; if_ack pulses 2 edges after request; if_rdata=0x0050_0093; d_ack stays 0.
- Store then load, MEM_LAT=3: store d_addr=0x100, d_wdata=0xDEAD_BEEF gives mem_we=1 for one cycle and d_ack 4 edges later with d_rdata=0. The following load from 0x100 returns 0xDEAD_BEEF.
- Simultaneous if_req and d_req held continuously, STARVE_GUARD_EN on, STARVE_MAX=4: grant sequence is D,D,D,D,F,D,D,D,D,F. With the macro off, fetch is never granted.
- Reset asserted in WAIT of a load: next cycle is IDLE, mem_en=0, no d_ack is ever produced for that load, and all outputs read 0.
- d_req dropped in the ISSUE cycle: d_ack still pulses at the normal edge and the FSM returns to IDLE. A pending if_req is served immediately after.
